uart_rx_fifo: RTL and testbench

//   Receive-side buffer directly downstream of the UART receiver. Detects each new completed

---
 rtl/uart_rx_fifo_pkg.sv | 6 +
 rtl/sync_fifo_mem.sv | 24 ++
 rtl/uart_rx_fifo.sv | 73 +++++++
 tb/tb_uart_rx_fifo.sv | 130 +++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared UART widths and RX FIFO defaults.
package uart_rx_fifo_pkg;
  localparam int UART_DATA_W    = 8;
  localparam int RX_FIFO_DEPTH  = 16;
  localparam int RX_FIFO_THRESH = 8;
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x DATA_W register array, synchronous write and registered read.
module sync_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  // only the read register is reset; the array keeps stale contents
  always_ff @(posedge clk)
    if (rst) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receiver-side byte FIFO with done-edge capture, status flags,
// threshold irq and sticky overflow.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = RX_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int THRESH = RX_FIFO_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] rx_byte,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              irq,
  output logic              overflow,
  input  logic              overflow_clr
);
  logic              done_q, rd_valid_q, empty_q, full_q, irq_q, ovf_q, ovf_d;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   level_q, level_d;
  logic              push, pop, wr;
  assign push    = rx_done & ~done_q;
  assign pop     = rd_en & ~empty_q;
  assign wr      = push & (~full_q | pop);
  assign level_d = level_q + {{ADDR_W{1'b0}}, wr} - {{ADDR_W{1'b0}}, pop};
  // overflow set has priority over clear
  assign ovf_d   = (push & full_q & ~pop) | (ovf_q & ~overflow_clr);
  always_ff @(posedge clk)
    if (rst) begin
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      irq_q      <= 1'b0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      done_q     <= rx_done;
      wr_ptr_q   <= wr ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
      rd_ptr_q   <= pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
      level_q    <= level_d;
      empty_q    <= level_d == '0;
      full_q     <= level_d == (ADDR_W+1)'(DEPTH);
      irq_q      <= level_d >= (ADDR_W+1)'(THRESH);
      ovf_q      <= ovf_d;
      rd_valid_q <= pop;
    end
  sync_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr),
    .waddr_i (wr_ptr_q),
    .wdata_i (rx_byte),
    .re_i    (pop),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );
  assign rd_valid = rd_valid_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign level    = level_q;
  assign irq      = irq_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scenarios plus random traffic checked against a queue model.
module tb_uart_rx_fifo;
  localparam int DW = 8, DEPTH = 16, AW = 4, THRESH = 8;
  logic          clk = 0, rst = 0, rx_done = 0, rd_en = 0, overflow_clr = 0;
  logic [DW-1:0] rx_byte = '0, rd_data;
  logic          rd_valid, empty, full, irq, overflow;
  logic [AW:0]   level;
  int            n_vec = 0, n_err = 0;
  logic [DW-1:0] m_q[$];
  logic          m_dprev = 0, m_ovf = 0, m_rv = 0;
  logic [DW-1:0] m_rdd = '0;
  uart_rx_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_byte(rx_byte), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full), .level(level),
    .irq(irq), .overflow(overflow), .overflow_clr(overflow_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // queue-based reference: pop before push so push+pop on full keeps the byte
  task automatic model_edge();
    bit p, q, was_full;
    if (rst) begin
      m_q.delete(); m_dprev = 0; m_ovf = 0; m_rdd = '0; m_rv = 0;
      return;
    end
    p = rx_done && !m_dprev;
    q = rd_en && m_q.size() > 0;
    was_full = m_q.size() == DEPTH;
    m_rv = q;
    if (q) m_rdd = m_q.pop_front();
    if (p && (!was_full || q)) m_q.push_back(rx_byte);
    if (p && was_full && !q) m_ovf = 1;
    else if (overflow_clr) m_ovf = 0;
    m_dprev = rx_done;
  endtask
  task automatic step(input logic r, input logic d, input logic [DW-1:0] b,
                      input logic rd, input logic clr);
    rst = r; rx_done = d; rx_byte = b; rd_en = rd; overflow_clr = clr;
    @(posedge clk);
    model_edge();
    #1;
    chk("level", 32'(level), 32'(m_q.size()));
    chk("empty", 32'(empty), 32'(m_q.size() == 0));
    chk("full", 32'(full), 32'(m_q.size() == DEPTH));
    chk("irq", 32'(irq), 32'(m_q.size() >= THRESH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("rd_valid", 32'(rd_valid), 32'(m_rv));
    chk("rd_data", 32'(rd_data), 32'(m_rdd));
  endtask
  task automatic push(input logic [DW-1:0] b);
    step(0, 1, b, 0, 0);
    step(0, 0, b, 0, 0);
  endtask
  task automatic pop();
    step(0, 0, '0, 1, 0);
  endtask
  initial begin
    // 1: held done gives a single push
    step(1, 0, '0, 0, 0);
    chk("rst_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 20; i++) step(0, 1, 8'hA5, 0, 0);
    chk("t1_level", 32'(level), 32'd1);
    step(0, 0, '0, 1, 0);
    chk("t1_rdata", 32'(rd_data), 32'hA5);
    chk("t1_rvalid", 32'(rd_valid), 32'd1);
    step(0, 0, '0, 0, 0);
    // 2: overfill, 0x55 is dropped
    for (int i = 0; i < 16; i++) push(DW'(i));
    push(8'h55);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      pop();
      chk("t2_order", 32'(rd_data), 32'(i));
    end
    step(0, 0, '0, 0, 1);
    // 3: push+pop on full
    for (int i = 0; i < 16; i++) push(8'h30 + DW'(i));
    step(0, 1, 8'h77, 1, 0);
    chk("t3_level", 32'(level), 32'd16);
    chk("t3_ovf", 32'(overflow), 32'd0);
    step(0, 0, '0, 0, 0);
    for (int i = 0; i < 16; i++) pop();
    chk("t3_last", 32'(rd_data), 32'h77);
    // 4: reads on empty, push with read on empty
    step(0, 0, '0, 1, 0);
    chk("t4_rv", 32'(rd_valid), 32'd0);
    step(0, 1, 8'h3C, 1, 0);
    chk("t4_level", 32'(level), 32'd1);
    chk("t4_rv2", 32'(rd_valid), 32'd0);
    step(0, 0, '0, 1, 0);
    chk("t4_data", 32'(rd_data), 32'h3C);
    // 5: threshold irq and clear-vs-set priority
    step(1, 0, '0, 0, 0);
    for (int i = 0; i < 7; i++) push(DW'(i + 100));
    chk("t5_irq7", 32'(irq), 32'd0);
    step(0, 1, 8'hEE, 0, 0);
    chk("t5_irq8", 32'(irq), 32'd1);
    step(0, 0, '0, 1, 0);
    chk("t5_irqpop", 32'(irq), 32'd0);
    for (int i = 0; i < 9; i++) push(DW'(i));
    step(0, 1, 8'h99, 0, 1);
    chk("t5_setwins", 32'(overflow), 32'd1);
    step(0, 0, '0, 0, 1);
    // 6: reset with queued data and done held high
    step(1, 0, '0, 0, 0);
    for (int i = 0; i < 5; i++) push(DW'(i + 200));
    step(1, 1, 8'h5A, 0, 0);
    chk("t6_level", 32'(level), 32'd0);
    step(0, 1, 8'h5A, 0, 0);
    chk("t6_push", 32'(level), 32'd1);
    step(0, 0, '0, 1, 0);
    chk("t6_data", 32'(rd_data), 32'h5A);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic d;
      d = ($urandom_range(0, 2) == 0) ? ~rx_done : rx_done;
      step($urandom_range(0, 499) == 0, d, d && rx_done ? rx_byte : DW'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
